ssc_sched: RTL and testbench
============================

Name: ssc_sched

Overview:
- Round-robin scheduler that shares one start/stop/clear control FSM (single level input A, clear pulse K1, stop pulse K2) among NREQ requesters.
- On grant, it drives the A line through a complete IDLE->START->STOP->CLEAR->IDLE walk.
- It checks for the K2 and K1 acknowledgements, then reports done or timeout to the granted requester.
- It sits between the requesting units and the single FSM instance; it is the only driver of A.

Parameters:
- NREQ, 4, number of requesters (2..8).
- HOLD_W, 8, width of the START-phase hold length.
- TMO, 16, maximum cycles to wait for each acknowledgement (K2, then K1) before error.

Ports:
- clk_i  in  1  clock, all logic on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NREQ  per-requester level request for one full cycle.
- hold_i  in  HOLD_W  START-phase length in cycles; sampled at grant.
- gnt_o  out  NREQ  one-hot grant, held for the whole transaction.
- done_o  out  NREQ  one-cycle pulse to the granted requester on successful completion.
- err_o  out  1  one-cycle pulse on acknowledgement timeout.
- busy_o  out  1  high whenever the state is not S_IDLE.
- a_o  out  1  drives the FSM input A; registered.
- k1_i  in  1  FSM clear acknowledgement; combinational, valid in the same cycle as a_o.
- k2_i  in  1  FSM stop acknowledgement; combinational, valid in the same cycle as a_o.

Behaviour:
- Reset (async assert, sync release): state S_IDLE; a_o, gnt_o, done_o, err_o and busy_o all 0; rr_ptr = NREQ-1, so requester 0 wins first; hold counter 0; timeout counter 0.
- Arbitration, in S_IDLE:
  - If any req_i bit is set, the winner is the first set bit searching upward, circularly, from rr_ptr+1.
  - Next cycle: gnt_o = onehot(winner), rr_ptr = winner, hold_q = max(hold_i,1), state S_RUN.
  - With no request, stay in S_IDLE.
- S_RUN: a_o=1; counter counts hold_q cycles, then go to S_LOW.
- S_LOW: a_o=0 for exactly 1 cycle (FSM moves START->STOP), then go to S_ARM.
- S_ARM: a_o=1; wait for k2_i.
  - k2_i=1 -> go to S_DISARM and clear the timeout counter.
  - No k2_i for TMO cycles -> go to S_ERR.
- S_DISARM: a_o=0; wait for k1_i.
  - k1_i=1 -> go to S_DONE.
  - No k1_i for TMO cycles -> go to S_ERR.
- S_DONE: done_o[winner]=1 for 1 cycle, gnt_o cleared, a_o=0, return to S_IDLE.
- S_ERR: err_o=1 for 1 cycle, gnt_o cleared, a_o=0, return to S_IDLE; done_o is not pulsed.
- Transaction length:
  - Minimum cycles from the grant edge to the done_o pulse is hold_q + 3.
  - Next arbitration occurs in the cycle after S_DONE or S_ERR.
- Request withdrawal: req_i deasserted mid-transaction is ignored; the cycle runs to completion. A new request from the same requester is honoured only after the others get a turn under round robin.
- Simultaneous events:
  - k1_i and k2_i are both only checked in their own state; a stray acknowledgement in another state is ignored.
  - If the timeout expires in the same cycle the acknowledgement arrives, the acknowledgement wins.
- hold_i is sampled only at grant; later changes have no effect.
- Counter widths: the hold counter is HOLD_W bits; the timeout counter is clog2(TMO+1) bits. Neither counter wraps; both are cleared on every state entry.
- Reset mid-operation: a_o drops to 0 immediately. The external FSM is reset by its own reset; this block does not re-drive it.

Decomposition:
- Package ssc_pkg holds:
  - State enum S_IDLE, S_RUN, S_LOW, S_ARM, S_DISARM, S_DONE, S_ERR.
  - Default constants for NREQ, HOLD_W and TMO.
- One sub-module, ssc_rr_arb: combinational round-robin pick taking req and ptr, producing onehot and index. It is instantiated once in ssc_sched.

Test Plan:
- Single request: req_i=0001, hold_i=3, target FSM attached -> gnt_o=0001; a_o high 3 cycles, low 1, then high until k2_i, then low until k1_i; done_o=0001 pulse 6 cycles after grant; err_o never asserts.
- Round robin: req_i=1111 held -> grants in order 0001, 0010, 0100, 1000, 0001, with exactly one done_o pulse per grant.
- hold_i=0 -> a_o high exactly 1 cycle in S_RUN; done_o pulse 4 cycles after grant.
- Timeout: k2_i tied 0, TMO=16 -> a_o high for 16 cycles in S_ARM, err_o pulse, no done_o, back to S_IDLE.
- Reset mid-op: assert rst_i during S_ARM -> a_o, gnt_o and busy_o go 0 asynchronously; after release, req_i=1000 and 0001 together grant 0001 first.
- Withdrawal: req_i[2] drops during S_RUN -> transaction still completes with done_o=0100.

Source files
------------

// File: rtl/ssc_pkg.sv
// Shared types and defaults for the start/stop/clear scheduler slice.
package ssc_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int HOLD_W_DEF = 8;
    localparam int TMO_DEF    = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_LOW    = 3'd2,
        S_ARM    = 3'd3,
        S_DISARM = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/ssc_rr_arb.sv
// Combinational round-robin pick: first set request searching upward,
// circularly, from ptr+1.
module ssc_rr_arb
    import ssc_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssc_sched.sv
// Round-robin scheduler that walks one shared start/stop/clear FSM through
// IDLE->START->STOP->CLEAR on behalf of the granted requester.
module ssc_sched
    import ssc_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int HOLD_W = HOLD_W_DEF,
    parameter int TMO    = TMO_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [HOLD_W-1:0] hold_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              a_o,
    input  logic              k1_i,
    input  logic              k2_i
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TW    = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    // Handshake: req_i is a level, sampled only in S_IDLE. gnt_o is one-hot
    // from the grant edge until the cycle done_o/err_o pulses (one cycle each);
    // req_i changes while gnt_o is held are ignored.

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr;
    logic [NREQ-1:0]   sel_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic [NREQ-1:0]   arb_onehot;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    ssc_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req    (req_i),
        .ptr    (rr_ptr),
        .onehot (arb_onehot),
        .idx    (arb_idx)
    );

    assign arb_any = |req_i;
    assign busy_o  = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (arb_any) state_d = S_RUN;
            S_RUN:    if (hold_cnt == hold_q - HOLD_W'(1)) state_d = S_LOW;
            S_LOW:    state_d = S_ARM;
            S_ARM: begin
                // An acknowledgement in the final timeout cycle still counts.
                if (k2_i)                     state_d = S_DISARM;
                else if (tmo_cnt == TMO_LAST) state_d = S_ERR;
            end
            S_DISARM: begin
                if (k1_i)                     state_d = S_DONE;
                else if (tmo_cnt == TMO_LAST) state_d = S_ERR;
            end
            S_DONE:   state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rr_ptr   <= IDX_W'(NREQ - 1);
            sel_q    <= '0;
            hold_q   <= '0;
            hold_cnt <= '0;
            tmo_cnt  <= '0;
            a_o      <= 1'b0;
            gnt_o    <= '0;
            done_o   <= '0;
            err_o    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && arb_any) begin
                rr_ptr <= arb_idx;
                sel_q  <= arb_onehot;
                hold_q <= (hold_i == '0) ? HOLD_W'(1) : hold_i;
            end
            if (state_d != state_q) begin
                hold_cnt <= '0;
                tmo_cnt  <= '0;
            end else begin
                if (state_q == S_RUN)
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                if (state_q == S_ARM || state_q == S_DISARM)
                    tmo_cnt <= tmo_cnt + TW'(1);
            end
            // Outputs are registered from the next state so they line up with state_q.
            a_o <= (state_d == S_RUN) || (state_d == S_ARM);
            if (state_d == S_RUN || state_d == S_LOW || state_d == S_ARM || state_d == S_DISARM)
                gnt_o <= (state_q == S_IDLE) ? arb_onehot : sel_q;
            else
                gnt_o <= '0;
            done_o <= (state_d == S_DONE) ? sel_q : '0;
            err_o  <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_ssc_sched.sv
// Bench for ssc_sched: attaches a behavioural start/stop/clear FSM and scores
// every done/err pulse against a round-robin reference.
module tb_ssc_sched;

    localparam int NREQ   = 4;
    localparam int HOLD_W = 8;
    localparam int TMO    = 16;
    localparam int W      = NREQ + 1;

    logic              clk_i;
    logic              rst_i;
    logic [NREQ-1:0]   req_i;
    logic [HOLD_W-1:0] hold_i;
    logic [NREQ-1:0]   gnt_o;
    logic [NREQ-1:0]   done_o;
    logic              err_o;
    logic              busy_o;
    logic              a_o;
    logic              k1_i;
    logic              k2_i;

    logic          k1_en, k2_en;
    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            m_ptr    = NREQ - 1;

    ssc_sched #(
        .NREQ   (NREQ),
        .HOLD_W (HOLD_W),
        .TMO    (TMO)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .hold_i (hold_i),
        .gnt_o  (gnt_o),
        .done_o (done_o),
        .err_o  (err_o),
        .busy_o (busy_o),
        .a_o    (a_o),
        .k1_i   (k1_i),
        .k2_i   (k2_i)
    );

    // clock / reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1, "watchdog");
    end

    // behavioural target FSM
    typedef enum logic [1:0] {F_IDLE, F_START, F_STOP, F_CLEAR} fsm_e;
    fsm_e fsm;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) fsm <= F_IDLE;
        else begin
            case (fsm)
                F_IDLE:  if (a_o)  fsm <= F_START;
                F_START: if (!a_o) fsm <= F_STOP;
                F_STOP:  if (k2_i) fsm <= F_CLEAR;
                F_CLEAR: if (k1_i) fsm <= F_IDLE;
                default: fsm <= F_IDLE;
            endcase
        end
    end

    assign k2_i = k2_en && (fsm == F_STOP) && a_o;
    assign k1_i = k1_en && (fsm == F_CLEAR) && !a_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        for (int i = 1; i <= NREQ; i++) begin
            int c;
            c = (ptr + i) % NREQ;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // scoreboard
    always @(negedge clk_i) begin
        if (!rst_i && (done_o != '0 || err_o)) begin
            if (exp_q.size() == 0)
                check("unexpected_result", {27'd0, err_o, done_o}, 32'd0);
            else
                check("result", {27'd0, err_o, done_o}, {27'd0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic do_reset();
        rst_i = 1'b1;
        req_i = '0;
        @(negedge clk_i);
        check("reset_outputs", {21'd0, a_o, busy_o, err_o, done_o, gnt_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        m_ptr = NREQ - 1;
        exp_q.delete();
        @(negedge clk_i);
    endtask

    task automatic start_txn(input logic [NREQ-1:0] req, input logic [HOLD_W-1:0] hold, input bit ok);
        int win;
        logic [NREQ-1:0] oh;
        req_i  = req;
        hold_i = hold;
        win = pick(req, m_ptr);
        oh  = NREQ'(1) << win;
        m_ptr = win;
        exp_q.push_back(ok ? {1'b0, oh} : {1'b1, {NREQ{1'b0}}});
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_i);
            if (gnt_o != '0) break;
        end
        check("gnt", {28'd0, gnt_o}, {28'd0, oh});
        hold_i = HOLD_W'($urandom_range(0, 255));
    endtask

    task automatic finish_txn(input logic [HOLD_W-1:0] hold, input bit ok);
        int heff, lat, acnt;
        heff = (hold == 0) ? 1 : int'(hold);
        lat = 0;
        acnt = 0;
        while (lat < 100) begin
            if (a_o) acnt++;
            if (done_o != '0 || err_o) break;
            @(negedge clk_i);
            lat++;
        end
        check(ok ? "done_latency" : "err_latency", lat, ok ? heff + 3 : heff + 1 + TMO);
        check("a_high_cycles", acnt, ok ? heff + 1 : heff + TMO);
        check("gnt_cleared", {28'd0, gnt_o}, 32'd0);
        @(negedge clk_i);
        check("idle_after", {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] rq;
        logic [HOLD_W-1:0] hd;
        rst_i  = 1'b1;
        req_i  = '0;
        hold_i = '0;
        k1_en  = 1'b1;
        k2_en  = 1'b1;
        do_reset();
        repeat (3) @(negedge clk_i);
        check("idle_no_req", {30'd0, busy_o, a_o}, 32'd0);

        // single request, hold 3
        start_txn(4'b0001, 8'd3, 1'b1);
        finish_txn(8'd3, 1'b1);
        req_i = '0;

        // round robin with all requests held
        do_reset();
        for (int i = 0; i < 5; i++) begin
            start_txn(4'b1111, 8'd2, 1'b1);
            finish_txn(8'd2, 1'b1);
        end
        req_i = '0;

        // hold of zero behaves as one
        start_txn(4'b0010, 8'd0, 1'b1);
        finish_txn(8'd0, 1'b1);

        // withdrawal mid-transaction
        start_txn(4'b0100, 8'd3, 1'b1);
        req_i = '0;
        finish_txn(8'd3, 1'b1);

        // random requests and hold lengths
        for (int i = 0; i < 8; i++) begin
            rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            hd = HOLD_W'($urandom_range(0, 5));
            start_txn(rq, hd, 1'b1);
            finish_txn(hd, 1'b1);
        end
        req_i = '0;

        // missing stop acknowledgement
        k2_en = 1'b0;
        start_txn(4'b0001, 8'd2, 1'b0);
        req_i = '0;
        finish_txn(8'd2, 1'b0);

        // reset while waiting in S_ARM
        do_reset();
        start_txn(4'b0100, 8'd2, 1'b1);
        req_i = '0;
        repeat (3) @(negedge clk_i);
        check("in_arm_a_high", {31'd0, a_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("async_reset", {26'd0, a_o, busy_o, gnt_o}, 32'd0);
        exp_q.delete();
        m_ptr = NREQ - 1;
        @(negedge clk_i);
        rst_i = 1'b0;
        k2_en = 1'b1;
        @(negedge clk_i);
        start_txn(4'b1001, 8'd1, 1'b1);
        req_i = '0;
        finish_txn(8'd1, 1'b1);

        repeat (3) @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
